// File: rtl/obs_spawn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : obs_spawn_ctrl
//  Description : Obstacle spawn scheduler. Counts frames per level-dependent
//                interval, allocates the lowest free slot from a fixed pool,
//                and launches the obstacle at a pseudo-random x position.
//                Holds one pending spawn while the pool is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module obs_spawn_ctrl #(
    parameter int         N_SLOT     = 4,
    parameter int         MAX_X      = 640,
    parameter int         OBS_SIZE   = 20,
    parameter int         SPAWN_BASE = 60,
    parameter int         SPAWN_STEP = 12,
    parameter logic [9:0] LFSR_SEED  = 10'h001
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_stop,
    input  logic              refr_tick,
    input  logic [1:0]        level,
    // Per-slot free pulse ("release" itself is a reserved word).
    input  logic [N_SLOT-1:0] slot_release,
    output logic [N_SLOT-1:0] slot_busy,
    output logic              spawn_valid,
    output logic [1:0]        spawn_idx,
    output logic [9:0]        spawn_x,
    output logic              pending,
    output logic [2:0]        busy_cnt
);

    localparam int         c_CNT_W = $clog2(SPAWN_BASE + 1);
    localparam logic [9:0] c_RANGE = 10'(MAX_X - OBS_SIZE);

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_frame_cnt;
    logic [c_CNT_W-1:0]  w_frame_cnt_nxt;
    logic [c_CNT_W-1:0]  w_ivl_m1;
    logic [9:0]          r_lfsr;
    logic [9:0]          w_x_mapped;
    logic [N_SLOT-1:0]   w_free;
    logic [N_SLOT-1:0]   w_grant_oh;
    logic [N_SLOT-1:0]   w_busy_nxt;
    logic [1:0]          w_grant_idx;
    logic                w_found;
    logic                w_any_free;
    logic                w_expire;
    logic                w_grant;
    logic                w_pending_nxt;
    logic [2:0]          w_busy_cnt_nxt;

    // Last frame index of the current interval; follows level immediately.
    assign w_ivl_m1   = c_CNT_W'(SPAWN_BASE - 1 - SPAWN_STEP * int'(level));
    // One conditional subtract folds the 10-bit LFSR into 0..R-1.
    assign w_x_mapped = (r_lfsr >= c_RANGE) ? (r_lfsr - c_RANGE) : r_lfsr;
    // A slot released this cycle is immediately reusable.
    assign w_free     = ~slot_busy | slot_release;
    assign w_any_free = |w_free;
    assign w_expire   = refr_tick && (r_frame_cnt >= w_ivl_m1);

    // Fixed-priority allocator: lowest free index wins.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = 2'd0;
        w_grant_oh  = '0;
        for (int i = 0; i < N_SLOT; i++) begin
            if (w_free[i] && !w_found) begin
                w_found       = 1'b1;
                w_grant_idx   = 2'(i);
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    // Next-state, frame counting and grant decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_frame_cnt_nxt = r_frame_cnt;
        w_grant         = 1'b0;
        w_pending_nxt   = pending;
        case (r_state)
            ST_STOP: begin
                w_frame_cnt_nxt = '0;
                w_pending_nxt   = 1'b0;
                w_state_nxt     = ST_RUN;
            end
            ST_RUN, ST_WAIT: begin
                if (refr_tick) begin
                    w_frame_cnt_nxt = w_expire ? '0 : r_frame_cnt + c_CNT_W'(1);
                end
                if (r_state == ST_RUN) begin
                    if (w_expire) begin
                        if (w_any_free) begin
                            w_grant = 1'b1;
                        end else begin
                            w_pending_nxt = 1'b1;
                            w_state_nxt   = ST_WAIT;
                        end
                    end
                end else if (w_any_free) begin
                    // Expiries seen while waiting collapse into this one spawn.
                    w_grant       = 1'b1;
                    w_pending_nxt = 1'b0;
                    w_state_nxt   = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_STOP;
            end
        endcase
        if (game_stop) begin
            w_state_nxt     = ST_STOP;
            w_frame_cnt_nxt = '0;
            w_pending_nxt   = 1'b0;
            w_grant         = 1'b0;
        end
    end

    // Pool update: releases clear, a grant in the same cycle wins its slot.
    always_comb begin
        if (game_stop || (r_state == ST_STOP)) begin
            w_busy_nxt = '0;
        end else begin
            w_busy_nxt = (slot_busy & ~slot_release) | (w_grant ? w_grant_oh : '0);
        end
        w_busy_cnt_nxt = 3'd0;
        for (int i = 0; i < N_SLOT; i++) begin
            w_busy_cnt_nxt = w_busy_cnt_nxt + 3'(w_busy_nxt[i]);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered outputs and frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_cnt <= '0;
            slot_busy   <= '0;
            busy_cnt    <= 3'd0;
            pending     <= 1'b0;
            spawn_valid <= 1'b0;
            spawn_idx   <= 2'd0;
            spawn_x     <= 10'd0;
        end else begin
            r_frame_cnt <= w_frame_cnt_nxt;
            slot_busy   <= w_busy_nxt;
            busy_cnt    <= w_busy_cnt_nxt;
            pending     <= w_pending_nxt;
            spawn_valid <= w_grant;
            if (w_grant) begin
                spawn_idx <= w_grant_idx;
                spawn_x   <= w_x_mapped;
            end
        end
    end

    // Free-running LFSR; runs in every state so player timing stirs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[8:0], r_lfsr[9] ^ r_lfsr[6]};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obs_spawn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_obs_spawn_ctrl
//  Description : Self-checking bench for obs_spawn_ctrl: directed scenarios
//                plus randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_obs_spawn_ctrl;

    localparam int         c_R    = 620;
    localparam logic [9:0] c_SEED = 10'h001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       game_stop = 1'b1;
    logic       refr_tick = 1'b0;
    logic [1:0] level = 2'd0;
    logic [3:0] slot_release = 4'd0;
    logic [3:0] slot_busy;
    logic       spawn_valid;
    logic [1:0] spawn_idx;
    logic [9:0] spawn_x;
    logic       pending;
    logic [2:0] busy_cnt;

    int checks   = 0;
    int failures = 0;

    // Model state: the LFSR sequence as a table, a pool bitmap and a request flag.
    logic [9:0] seq [0:1022];
    bit         m_active;
    bit         m_pend;
    int         m_cnt;
    logic [3:0] m_busy;
    int         m_k;
    bit         e_valid;
    int         e_idx;
    int         e_x;

    obs_spawn_ctrl #(
        .N_SLOT     (4),
        .MAX_X      (640),
        .OBS_SIZE   (20),
        .SPAWN_BASE (60),
        .SPAWN_STEP (12),
        .LFSR_SEED  (c_SEED)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .game_stop    (game_stop),
        .refr_tick    (refr_tick),
        .level        (level),
        .slot_release (slot_release),
        .slot_busy    (slot_busy),
        .spawn_valid  (spawn_valid),
        .spawn_idx    (spawn_idx),
        .spawn_x      (spawn_x),
        .pending      (pending),
        .busy_cnt     (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int map_x(input logic [9:0] v);
        int iv;
        iv = int'(v);
        return (iv >= c_R) ? iv - c_R : iv;
    endfunction

    // Behavioural model: advances one clock at each rising edge.
    always @(posedge clk) begin : mdl
        int         lf_x;
        int         ivl;
        bit         want;
        logic [3:0] free;
        if (rst) begin
            m_active = 0; m_pend = 0; m_cnt = 0; m_busy = 4'd0;
            m_k = 0; e_valid = 0; e_idx = 0; e_x = 0;
        end else begin
            lf_x = map_x(seq[m_k % 1023]);
            m_k++;
            e_valid = 0;
            if (game_stop) begin
                m_active = 0; m_pend = 0; m_cnt = 0; m_busy = 4'd0;
            end else if (!m_active) begin
                m_active = 1;
            end else begin
                ivl  = 60 - 12 * int'(level);
                want = m_pend;
                if (refr_tick) begin
                    if (m_cnt + 1 >= ivl) begin
                        m_cnt = 0;
                        want  = 1;
                    end else begin
                        m_cnt++;
                    end
                end
                free   = ~m_busy | slot_release;
                m_busy = m_busy & ~slot_release;
                if (want && free != 4'd0) begin
                    for (int i = 3; i >= 0; i--) if (free[i]) e_idx = i;
                    m_busy[e_idx] = 1'b1;
                    e_valid = 1;
                    e_x     = lf_x;
                    m_pend  = 0;
                end else begin
                    m_pend = want;
                end
            end
        end
    end

    // Compare DUT outputs with the model away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("slot_busy",   slot_busy,   m_busy);
            chk("pending",     pending,     m_pend);
            chk("busy_cnt",    busy_cnt,    $countones(m_busy));
            chk("spawn_valid", spawn_valid, e_valid);
            if (e_valid) chk("spawn_idx", spawn_idx, e_idx);
            chk("spawn_x",       spawn_x, e_x);
            chk("spawn_x_range", (spawn_x <= 10'd619), 1);
        end
    end

    // Tick every cycle for n frames; the first spawn must land after tick n.
    task automatic expect_first_spawn(input int n, input string nm);
        int first_t;
        int spawns;
        first_t = 0;
        spawns  = 0;
        refr_tick = 1'b1;
        for (int t = 1; t <= n; t++) begin
            @(negedge clk);
            if (spawn_valid) begin
                spawns++;
                if (first_t == 0) first_t = t;
            end
        end
        refr_tick = 1'b0;
        chk({nm, "_tick"},  first_t, n);
        chk({nm, "_count"}, spawns,  1);
    endtask

    initial begin : stim
        logic [9:0] v;
        int         zeros;
        int         early;
        int         spawns;
        int         rate;

        // Build and pin the LFSR table.
        seq[0] = c_SEED;
        for (int i = 1; i < 1023; i++) begin
            v = seq[i-1];
            seq[i] = {v[8:0], v[9] ^ v[6]};
        end
        zeros = 0;
        early = 0;
        for (int i = 0; i < 1023; i++) begin
            if (seq[i] == 10'd0) zeros++;
            if (i > 0 && seq[i] == c_SEED) early++;
        end
        v = seq[1022];
        chk("lfsr_nonzero",       zeros, 0);
        chk("lfsr_no_early_wrap", early, 0);
        chk("lfsr_period_1023",   {v[8:0], v[9] ^ v[6]}, c_SEED);
        chk("lfsr_seq7",          seq[7], 10'h081);

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_slot_busy",   slot_busy,   0);
        chk("rst_spawn_valid", spawn_valid, 0);
        chk("rst_spawn_idx",   spawn_idx,   0);
        chk("rst_spawn_x",     spawn_x,     0);
        chk("rst_pending",     pending,     0);
        chk("rst_busy_cnt",    busy_cnt,    0);
        rst = 1'b0;
        game_stop = 1'b0;
        level = 2'd0;
        @(negedge clk);

        // Basic spawn at level 0.
        expect_first_spawn(60, "basic");
        chk("basic_idx",      spawn_idx, 0);
        chk("basic_busy",     slot_busy, 4'b0001);
        chk("basic_busy_cnt", busy_cnt,  1);
        chk("basic_x_lt_620", (spawn_x < 10'd620), 1);

        // Level 3: fills slots 1..3, fifth expiry goes pending.
        level = 2'd3;
        refr_tick = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            repeat (24) @(negedge clk);
            if (e < 4) begin
                chk("l3_valid", spawn_valid, 1);
                chk("l3_idx",   spawn_idx,   e);
            end else begin
                chk("l3_full_valid",   spawn_valid, 0);
                chk("l3_full_pending", pending,     1);
            end
        end
        refr_tick = 1'b0;
        slot_release = 4'b0100;
        @(negedge clk);
        slot_release = 4'b0000;
        chk("wait_rel_valid",   spawn_valid, 1);
        chk("wait_rel_idx",     spawn_idx,   2);
        chk("wait_rel_pending", pending,     0);
        chk("wait_rel_busy",    slot_busy,   4'b1111);

        // Expiring tick coincides with release of slot 1.
        refr_tick = 1'b1;
        repeat (23) @(negedge clk);
        slot_release = 4'b0010;
        @(negedge clk);
        refr_tick = 1'b0;
        slot_release = 4'b0000;
        chk("same_cyc_valid",   spawn_valid, 1);
        chk("same_cyc_idx",     spawn_idx,   1);
        chk("same_cyc_busy",    slot_busy,   4'b1111);
        chk("same_cyc_pending", pending,     0);

        // Level change after 40 frames at level 0.
        slot_release = 4'b0001;
        @(negedge clk);
        slot_release = 4'b0000;
        level = 2'd0;
        refr_tick = 1'b1;
        spawns = 0;
        repeat (40) begin
            @(negedge clk);
            if (spawn_valid) spawns++;
        end
        chk("lvl_chg_no_early", spawns, 0);
        level = 2'd2;
        @(negedge clk);
        refr_tick = 1'b0;
        chk("lvl_chg_valid", spawn_valid, 1);
        chk("lvl_chg_idx",   spawn_idx,   0);

        // Game stop while waiting with a full pool.
        level = 2'd3;
        refr_tick = 1'b1;
        repeat (24) @(negedge clk);
        refr_tick = 1'b0;
        chk("stop_pre_pending", pending, 1);
        game_stop = 1'b1;
        @(negedge clk);
        chk("stop_busy",     slot_busy, 0);
        chk("stop_pending",  pending,   0);
        chk("stop_busy_cnt", busy_cnt,  0);
        game_stop = 1'b0;
        level = 2'd0;
        @(negedge clk);
        expect_first_spawn(60, "after_stop");

        // Asynchronous reset mid-operation.
        refr_tick = 1'b1;
        repeat (30) @(negedge clk);
        refr_tick = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy",     slot_busy, 0);
        chk("async_rst_busy_cnt", busy_cnt,  0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_first_spawn(60, "after_rst");

        // Randomized traffic; the compare process checks every cycle.
        rate = 20;
        for (int c = 0; c < 60000; c++) begin
            if (c % 2000 == 0) rate = ($urandom_range(1) == 0) ? 8 : 200;
            if ($urandom_range(499) == 0) level = 2'($urandom_range(3));
            refr_tick = ($urandom_range(7) != 0);
            for (int b = 0; b < 4; b++) slot_release[b] = ($urandom_range(rate - 1) == 0);
            game_stop = ($urandom_range(2999) == 0);
            @(negedge clk);
        end
        refr_tick = 1'b0;
        slot_release = 4'b0000;
        game_stop = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
